fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MCU. Owns the program counter and issues one instruction-memory read at a time.
- Buffers the returned instruction plus its PC in a one-entry output register that feeds the IF/ID pipeline register.
- Honours decode stalls from the hazard unit and branch/jump redirects from EX, discarding any wrong-path fetch in flight.

Parameters:
- WIDTH, 32, address and instruction width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous reset, active-low.
- stall  input  1  decode cannot accept this cycle (hazard unit).
- redirect_valid  input  1  single-cycle branch/jump taken from EX.
- redirect_pc  input  WIDTH  redirect target; bits [1:0] ignored and treated as 0.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  WIDTH  read address; equals pc.
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid; at most one per accepted request; arrives no earlier than the cycle after acceptance.
- imem_rdata  input  WIDTH  instruction word.
- out_valid  output  1  output buffer holds a valid instruction.
- out_instr  output  WIDTH  buffered instruction.
- out_pc  output  WIDTH  PC of out_instr.
- out_pc_plus4  output  WIDTH  out_pc+4, modulo 2^WIDTH.

Behaviour:
- Reset (asynchronous on reset_n=0):
  - pc=RESET_PC, state=ISSUE, out_valid=0.
  - out_instr=0, out_pc=0, out_pc_plus4=0.
  - imem_req=0 while reset_n=0.
- consume = out_valid & ~stall. A consume empties the buffer at the next edge unless the buffer is reloaded.
- can_issue = ~out_valid | consume. This guarantees the buffer is empty whenever a response returns.
- States:
  - ISSUE: imem_req = can_issue & ~redirect_valid; imem_addr=pc.
    - imem_req & imem_ready -> WAIT.
    - Otherwise stay in ISSUE.
  - WAIT: imem_req=0.
    - On imem_rvalid & ~redirect_valid: load out_instr=imem_rdata, out_pc=pc, out_pc_plus4=pc+4, out_valid=1, pc<=pc+4, go to ISSUE.
  - DROP: imem_req=0. A wrong-path response is outstanding.
    - On imem_rvalid: discard the data, go to ISSUE.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[WIDTH-1:2],2'b00}.
  - out_valid <= 0 (flush), regardless of stall or consume.
  - ISSUE: stay ISSUE. No request is made in the redirect cycle.
  - WAIT with imem_rvalid=0: go to DROP.
  - WAIT with imem_rvalid=1 the same cycle: discard the response, go to ISSUE.
  - DROP: stay DROP, or go to ISSUE if imem_rvalid=1 that cycle. The pc takes the newest target.
- Latency:
  - Request accepted in cycle N with response in N+1 gives out_valid=1 in N+2.
  - Peak throughput is 1 instruction per 2 cycles with a 1-cycle memory and no stall.
- Stall: held output fields (out_valid/out_instr/out_pc/out_pc_plus4) stay stable while stall=1. No new request is issued while the buffer is full and not consumed.
- PC arithmetic: pc+4 wraps modulo 2^WIDTH, e.g. 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset mid-operation: the FSM and buffer clear immediately. Any response in flight after reset release is not expected; memory is reset on the same reset_n.

Test Plan:
- Reset release, imem_ready=1, 1-cycle memory returning 32'h1111_0000+addr, stall=0 -> first request addr 0x0. out_valid with out_pc=0x0, out_instr=32'h1111_0000, out_pc_plus4=0x4 two cycles later. Then PCs 0x4, 0x8 at 2-cycle spacing.
- stall=1 for 5 cycles while out_valid=1 at out_pc=0x8 -> imem_req=0 and outputs unchanged throughout. Fetch of 0xC is requested the cycle stall drops.
- redirect_valid with redirect_pc=0x103 while WAIT for 0x10, response 2 cycles later -> state DROP, 0x10 data never appears on out_*. Next request addr 0x100.
- redirect_valid in the same cycle as imem_rvalid and with out_valid=1, stall=1 -> out_valid=0 next cycle, response discarded. Next request at the redirect target.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0000_0000. out_pc_plus4 of the first instruction is 0x0.
- reset_n pulsed low while WAIT with out_valid=1 -> out_valid=0 and imem_req=0 asynchronously. After release the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one imem read at a time and buffers the
// returned instruction with its PC; redirects flush the buffer and drop wrong-path reads.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_plus4
);
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DROP} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_plus4, w_target;
  logic             w_consume, w_can_issue, w_load;
  assign w_consume   = out_valid & ~stall;
  assign w_can_issue = ~out_valid | w_consume;
  assign w_load      = (r_state == S_WAIT) & imem_rvalid & ~redirect_valid;
  assign w_pc_plus4  = r_pc + WIDTH'(4);
  assign w_target    = redirect_pc & ~WIDTH'(3);
  assign imem_addr   = r_pc;
  // Gated by reset_n so no request escapes while the block is held in reset.
  assign imem_req    = reset_n & (r_state == S_ISSUE) & w_can_issue & ~redirect_valid;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_ISSUE)
      w_state_nxt = (imem_req & imem_ready) ? S_WAIT : S_ISSUE;
    else if (r_state == S_WAIT)
      w_state_nxt = imem_rvalid ? S_ISSUE : (redirect_valid ? S_DROP : S_WAIT);
    else
      w_state_nxt = imem_rvalid ? S_ISSUE : S_DROP;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_ISSUE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= redirect_valid ? w_target : (w_load ? w_pc_plus4 : r_pc);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
    end else begin
      out_valid <= redirect_valid ? 1'b0 : (w_load ? 1'b1 : (w_consume ? 1'b0 : out_valid));
      if (w_load) begin
        out_instr    <= imem_rdata;
        out_pc       <= r_pc;
        out_pc_plus4 <= w_pc_plus4;
      end
    end
  end
endmodule
